// File: rtl/clock_meter.sv
// clock_meter
// Measures the period and high time of a slow, possibly asynchronous clock
// (clk_in) in units of clk cycles, and flags a stall when no rising edge of
// clk_in arrives within TIMEOUT cycles.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no reference edge held; counters parked at 0
// MEASURE | reference edge held; cnt/hcnt counting
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   clk_in       in   clock under measurement
//   period       out  clk cycles between the last two rises of clk_in
//   high_time    out  clk cycles clk_in was high within that period
//   period_valid out  one-cycle pulse when period/high_time update
//   stalled      out  no rise within TIMEOUT cycles; clears on next period_valid
//   measuring    out  registered (state == MEASURE)
module clock_meter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             stalled,
  output logic             measuring
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TMO  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             rise, timeout;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] hcnt, hcnt_nx;
  logic [WIDTH-1:0] period_nx, high_time_nx;
  logic             period_valid_nx, stalled_nx, measuring_nx;

  assign rise    = s2 & ~s3;
  assign timeout = (cnt == TMO);

  // state register plus all datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= IDLE;
      cnt          <= ZERO;
      hcnt         <= ZERO;
      period       <= ZERO;
      high_time    <= ZERO;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      measuring    <= 1'b0;
    end else begin
      s1           <= clk_in;
      s2           <= s1;
      s3           <= s2;
      state        <= state_nx;
      cnt          <= cnt_nx;
      hcnt         <= hcnt_nx;
      period       <= period_nx;
      high_time    <= high_time_nx;
      period_valid <= period_valid_nx;
      stalled      <= stalled_nx;
      measuring    <= measuring_nx;
    end
  end

  // next-state logic; a rise coinciding with timeout keeps us in MEASURE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = MEASURE;
      MEASURE: if (!rise && timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs and counters
  always_comb begin
    cnt_nx          = cnt;
    hcnt_nx         = hcnt;
    period_nx       = period;
    high_time_nx    = high_time;
    period_valid_nx = 1'b0;
    stalled_nx      = stalled;
    case (state)
      IDLE: begin
        cnt_nx  = ZERO;
        // the rise cycle itself has s2 high, so the high count starts at 1
        hcnt_nx = rise ? ONE : ZERO;
      end
      MEASURE: begin
        if (rise) begin
          period_nx       = cnt + ONE;
          high_time_nx    = hcnt;
          period_valid_nx = 1'b1;
          stalled_nx      = 1'b0;
          cnt_nx          = ZERO;
          hcnt_nx         = ONE;
        end else if (timeout) begin
          stalled_nx = 1'b1;
          cnt_nx     = ZERO;
          hcnt_nx    = ZERO;
        end else begin
          cnt_nx  = cnt + ONE;
          hcnt_nx = hcnt + {{(WIDTH-1){1'b0}}, s2};
        end
      end
      default: begin
        cnt_nx  = ZERO;
        hcnt_nx = ZERO;
      end
    endcase
    measuring_nx = (state_nx == MEASURE);
  end

endmodule

// File: tb/tb_clock_meter.sv
module tb_clock_meter;
  localparam int W   = 16;
  localparam int TMO = 20;

  typedef struct packed {
    logic         pv;
    logic [W-1:0] per;
    logic [W-1:0] ht;
    logic         st;
    logic         ms;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         period_valid, stalled, measuring;

  int checks = 0;
  int errors = 0;

  bit   wave[$];
  rec_t obs[$];
  rec_t exp_q[$];

  clock_meter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in),
    .period(period), .high_time(high_time), .period_valid(period_valid),
    .stalled(stalled), .measuring(measuring)
  );

  always #5 clk = ~clk;

  task automatic add_seg(input bit lvl, input int len);
    repeat (len) wave.push_back(lvl);
  endtask

  // Ends on a negedge with reset released.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts and ends on a negedge. obs[n] holds outputs after edge n sampled wave[n].
  task automatic play();
    obs.delete();
    for (int n = 0; n < wave.size(); n++) begin
      clk_in = wave[n];
      @(posedge clk);
      #1;
      obs.push_back({period_valid, period, high_time, stalled, measuring});
      @(negedge clk);
    end
  endtask

  // Reference: the meter acts at edge n when the input rose two samples
  // earlier. A measurement spans two consecutive acting rises; a gap longer
  // than TMO+1 edges declares a stall and the next rise only re-arms.
  task automatic build_exp();
    rec_t r;
    int   last;
    bit   armed;
    bit   rise_n;
    int   h;
    r = '0;
    armed = 0;
    last = 0;
    exp_q.delete();
    for (int n = 0; n < wave.size(); n++) begin
      rise_n = 0;
      if (n >= 2 && wave[n-2]) begin
        rise_n = 1;
        if (n >= 3 && wave[n-3]) rise_n = 0;
      end
      r.pv = 1'b0;
      if (rise_n) begin
        if (armed) begin
          h = 0;
          for (int k = last - 2; k <= n - 3; k++) h += int'(wave[k]);
          r.per = W'(n - last);
          r.ht  = W'(h);
          r.pv  = 1'b1;
          r.st  = 1'b0;
        end
        armed = 1;
        last  = n;
      end else if (armed && (n - last) == TMO + 1) begin
        r.st  = 1'b1;
        armed = 0;
      end
      r.ms = armed;
      exp_q.push_back(r);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    clk_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({period_valid, period, high_time, stalled, measuring} !== '0) begin
        errors++;
        $display("FAIL reset cyc %0d: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want all 0",
                 i, period_valid, period, high_time, stalled, measuring);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_divider(input string name, input int hi, input int lo, input int reps);
    int npv;
    wave.delete();
    add_seg(0, 2);
    for (int i = 0; i < reps; i++) begin
      add_seg(1, hi);
      add_seg(0, lo);
    end
    apply_reset();
    play();
    build_exp();
    npv = 0;
    for (int n = 0; n < obs.size(); n++) begin
      checks++;
      if (obs[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL %s cyc %0d: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want pv=%0b per=%0d ht=%0d st=%0b ms=%0b",
                 name, n, obs[n].pv, obs[n].per, obs[n].ht, obs[n].st, obs[n].ms,
                 exp_q[n].pv, exp_q[n].per, exp_q[n].ht, exp_q[n].st, exp_q[n].ms);
      end
      if (obs[n].pv) begin
        npv++;
        checks++;
        if (obs[n].per !== W'(hi + lo) || obs[n].ht !== W'(hi)) begin
          errors++;
          $display("FAIL %s value cyc %0d: got per=%0d ht=%0d, want per=%0d ht=%0d",
                   name, n, obs[n].per, obs[n].ht, hi + lo, hi);
        end
      end
    end
    checks++;
    if (npv != reps - 1) begin
      errors++;
      $display("FAIL %s pulse count: got %0d, want %0d", name, npv, reps - 1);
    end
  endtask

  task automatic test_stall();
    int lastpv;
    wave.delete();
    add_seg(0, 2);
    for (int i = 0; i < 5; i++) begin add_seg(1, 4); add_seg(0, 4); end
    add_seg(0, 40);
    for (int i = 0; i < 3; i++) begin add_seg(1, 3); add_seg(0, 3); end
    add_seg(0, 3);
    apply_reset();
    play();
    build_exp();
    lastpv = -1;
    for (int n = 0; n < 50; n++) if (exp_q[n].pv) lastpv = n;
    for (int n = 0; n < obs.size(); n++) begin
      checks++;
      if (obs[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL stall cyc %0d: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want pv=%0b per=%0d ht=%0d st=%0b ms=%0b",
                 n, obs[n].pv, obs[n].per, obs[n].ht, obs[n].st, obs[n].ms,
                 exp_q[n].pv, exp_q[n].per, exp_q[n].ht, exp_q[n].st, exp_q[n].ms);
      end
    end
    checks++;
    if (lastpv < 0 || obs[lastpv+20].st !== 1'b0 || obs[lastpv+21].st !== 1'b1 ||
        obs[lastpv+21].ms !== 1'b0 || obs[lastpv+21].per !== W'(8)) begin
      errors++;
      $display("FAIL stall timing: lastpv=%0d st@20=%0b st@21=%0b ms@21=%0b per@21=%0d, want 0 1 0 8",
               lastpv, obs[lastpv+20].st, obs[lastpv+21].st, obs[lastpv+21].ms, obs[lastpv+21].per);
    end
  endtask

  task automatic test_boundary(input string name, input int gap, input int want_pv);
    int npv;
    bit saw_stall;
    wave.delete();
    add_seg(0, 2);
    for (int i = 0; i < 4; i++) begin add_seg(1, 1); add_seg(0, gap - 1); end
    apply_reset();
    play();
    build_exp();
    npv = 0;
    saw_stall = 0;
    for (int n = 0; n < obs.size(); n++) begin
      checks++;
      if (obs[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL %s cyc %0d: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want pv=%0b per=%0d ht=%0d st=%0b ms=%0b",
                 name, n, obs[n].pv, obs[n].per, obs[n].ht, obs[n].st, obs[n].ms,
                 exp_q[n].pv, exp_q[n].per, exp_q[n].ht, exp_q[n].st, exp_q[n].ms);
      end
      if (obs[n].pv) begin
        npv++;
        checks++;
        if (obs[n].per !== W'(gap) || obs[n].st !== 1'b0) begin
          errors++;
          $display("FAIL %s value cyc %0d: got per=%0d st=%0b, want per=%0d st=0",
                   name, n, obs[n].per, obs[n].st, gap);
        end
      end
      if (obs[n].st) saw_stall = 1;
    end
    checks++;
    if (npv != want_pv || saw_stall != (want_pv == 0)) begin
      errors++;
      $display("FAIL %s summary: got pulses=%0d stall=%0b, want pulses=%0d stall=%0b",
               name, npv, saw_stall, want_pv, want_pv == 0);
    end
  endtask

  task automatic test_reset_mid();
    int first_pv;
    wave.delete();
    add_seg(0, 2);
    for (int i = 0; i < 3; i++) begin add_seg(1, 3); add_seg(0, 3); end
    add_seg(1, 2);
    apply_reset();
    play();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({period_valid, period, high_time, stalled, measuring} !== '0) begin
      errors++;
      $display("FAIL reset_mid clear: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want all 0",
               period_valid, period, high_time, stalled, measuring);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // clk_in already high at release: must act as an ordinary arming rise
    wave.delete();
    for (int i = 0; i < 3; i++) begin add_seg(1, 4); add_seg(0, 3); end
    add_seg(0, 2);
    play();
    build_exp();
    first_pv = -1;
    for (int n = 0; n < obs.size(); n++) begin
      checks++;
      if (obs[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want pv=%0b per=%0d ht=%0d st=%0b ms=%0b",
                 n, obs[n].pv, obs[n].per, obs[n].ht, obs[n].st, obs[n].ms,
                 exp_q[n].pv, exp_q[n].per, exp_q[n].ht, exp_q[n].st, exp_q[n].ms);
      end
      if (obs[n].pv && first_pv < 0) first_pv = n;
    end
    checks++;
    if (first_pv != 9 || obs[9].per !== W'(7) || obs[9].ht !== W'(4)) begin
      errors++;
      $display("FAIL reset_mid first pulse: got cyc=%0d, want cyc=9 per=7 ht=4", first_pv);
    end
  endtask

  task automatic test_random();
    wave.delete();
    add_seg(0, $urandom_range(1, 4));
    for (int i = 0; i < 40; i++) begin
      add_seg(1, $urandom_range(1, 10));
      if ($urandom_range(0, 5) == 0) add_seg(0, $urandom_range(18, 26));
      else add_seg(0, $urandom_range(1, 12));
    end
    apply_reset();
    play();
    build_exp();
    for (int n = 0; n < obs.size(); n++) begin
      checks++;
      if (obs[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL random cyc %0d: got pv=%0b per=%0d ht=%0d st=%0b ms=%0b, want pv=%0b per=%0d ht=%0d st=%0b ms=%0b",
                 n, obs[n].pv, obs[n].per, obs[n].ht, obs[n].st, obs[n].ms,
                 exp_q[n].pv, exp_q[n].per, exp_q[n].ht, exp_q[n].st, exp_q[n].ms);
      end
      checks++;
      if (obs[n].ht > obs[n].per) begin
        errors++;
        $display("FAIL random ht_le_per cyc %0d: got ht=%0d per=%0d, want ht<=per",
                 n, obs[n].ht, obs[n].per);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divider("div50", 2, 2, 10);
    test_divider("div5", 5, 5, 6);
    test_divider("asym", 3, 7, 6);
    test_stall();
    test_boundary("gap21", 21, 3);
    test_boundary("gap22", 22, 0);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
